map_arbiter: RTL and testbench
==============================

MAP_ARBITER -- requirements
Module: map_arbiter

Interface
REQ-001 The block SHALL take parameter NUM_MAP, default 5: number of coprocessor mapper channels; channel 0 is the plain LoROM/HiROM default, channels 1..NUM_MAP are the coprocessors.
REQ-002 The block SHALL take parameter ROM_AW, default 24: ROM address width.
REQ-003 The block SHALL take parameter BSRAM_AW, default 20: BSRAM address width.
REQ-004 The block SHALL take parameter QUIET_CYC, default 2: bus-quiet cycles on an owner change (0..15).
REQ-005 The block SHALL take parameter NO_TURBO_MASK, default 5'b01010: channels 1..NUM_MAP that forbid CPU turbo.
REQ-006 mclk  in  1  system master clock; the block SHALL have one clock only.
REQ-007 rst_n  in  1  reset; the block SHALL treat it as asynchronous and active-low.
REQ-008 map_active  in  NUM_MAP  bit k SHALL request channel k+1.
REQ-009 ch_do, ch_irq_n, ch_rom_addr, ch_rom_ce_n, ch_rom_oe_n, ch_rom_word, ch_bsram_addr, ch_bsram_d, ch_bsram_ce_n, ch_bsram_oe_n, ch_bsram_we_n  in  (NUM_MAP+1) x field width  per-channel buses, flattened, channel 0 in the LSBs.
REQ-010 di, irq_n, rom_addr, rom_ce_n, rom_oe_n, rom_word, bsram_addr, bsram_d, bsram_ce_n, bsram_oe_n, bsram_we_n  out  field width  selected bus.
REQ-011 sel_idx  out  clog2(NUM_MAP+1)  current owner channel.
REQ-012 switching  out  1  SHALL be high while in DRAIN.
REQ-013 conflict  out  1  sticky flag: more than one map_active bit was seen high.
REQ-014 turbo_allow  out  1  CPU turbo permitted.

Function
REQ-015 The requested index SHALL be 0 when map_active is zero, k+1 when only bit k is set, and 0 when more than one bit is set.
REQ-016 The FSM SHALL have two states, OWN and DRAIN.
REQ-017 In OWN, a requested index that differs from cur_idx SHALL latch pend_idx and load cnt=QUIET_CYC-1 on the next edge, then enter DRAIN; with QUIET_CYC=0 it SHALL instead load cur_idx directly and stay in OWN.
REQ-018 In DRAIN, if the requested index changes, pend_idx SHALL be updated and cnt SHALL be reloaded; otherwise cnt SHALL decrement.
REQ-019 In DRAIN at cnt=0, cur_idx SHALL take pend_idx and the FSM SHALL return to OWN.
REQ-020 A DRAIN whose request reverts to the current cur_idx SHALL still complete the full count.
REQ-021 In OWN, all outputs in REQ-010 SHALL combinationally mirror channel cur_idx, with zero added latency.
REQ-022 In DRAIN, all _n strobes SHALL be 1, irq_n SHALL be 1, di SHALL be 8'hFF, and addresses and data SHALL hold channel pend_idx values.
REQ-023 A ch_rom_addr narrower than ROM_AW SHALL be zero-extended.
REQ-024 conflict SHALL set on any cycle in which popcount(map_active) exceeds 1, and SHALL clear only on reset.
REQ-025 turbo_allow SHALL be 0 in DRAIN or when cur_idx is a channel flagged in NO_TURBO_MASK, and 1 otherwise.
REQ-026 The request-to-ownership latency SHALL be exactly QUIET_CYC+1 cycles, or 1 cycle when QUIET_CYC=0.

Reset
REQ-027 On rst_n low, the block SHALL asynchronously set: state=OWN, cur_idx=0, pend_idx=0, cnt=0, conflict=0.
REQ-028 During and directly after reset, the outputs SHALL be: mirror of channel 0, switching=0, sel_idx=0, turbo_allow=1.
REQ-029 Reset asserted during DRAIN SHALL abort the switch, with no residual state.

Configuration
REQ-030 With macro MAP_ARB_CONFLICT_LOG_EN defined, the block SHALL add output conflict_vec (NUM_MAP), which captures the map_active value of the first conflict and holds it until reset.
REQ-031 With MAP_ARB_CONFLICT_LOG_EN defined, the block SHALL add output conflict_cnt (8), which counts rising edges of the conflict condition and saturates at 255.
REQ-032 Without MAP_ARB_CONFLICT_LOG_EN, these ports and registers SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 Shared package map_arb_pkg SHALL hold the state enum (OWN, DRAIN), DFLT_CH=0 and DRAIN_DI=8'hFF.
REQ-034 A single sub-module map_onehot_dec SHALL implement REQ-015 and the conflict detection: inputs map_active, outputs req_idx and multi.

Verification
REQ-035 Reset, then map_active=0 -> sel_idx=0, outputs mirror channel 0, turbo_allow=1.
REQ-036 QUIET_CYC=2, map_active=5'b00100 at cycle t -> switching high t+1..t+2, rom_ce_n=1 in DRAIN, sel_idx=3 and channel 3 mirrored at t+3.
REQ-037 map_active=5'b00011 -> sel_idx returns to 0 and conflict=1, which persists after map_active=0; with the macro defined, conflict_vec=5'b00011 and conflict_cnt=1.
REQ-038 Request changes 00100->01000 mid-DRAIN -> counter reloads, final sel_idx=4, turbo_allow=0 (NO_TURBO_MASK).
REQ-039 rst_n pulsed low during DRAIN -> sel_idx=0 and switching=0 immediately, without waiting for a clock.
REQ-040 QUIET_CYC=0, map_active=5'b00001 -> sel_idx=1 one cycle later, and switching never asserts.

Source files
------------

// File: rtl/map_arb_pkg.sv
// Shared types and constants for the mapper-channel arbiter.
package map_arb_pkg;

  typedef enum logic {
    OWN   = 1'b0,
    DRAIN = 1'b1
  } map_state_t;

  localparam int unsigned DFLT_CH  = 0;
  localparam logic [7:0]  DRAIN_DI = 8'hFF;

endpackage

// File: rtl/map_onehot_dec.sv
// Mapper request decoder: single request -> channel index, none or several -> default channel.
module map_onehot_dec #(
  parameter int unsigned NUM_MAP = 5,
  parameter int unsigned IDX_W   = $clog2(NUM_MAP + 1)
) (
  input  logic [NUM_MAP-1:0] map_active,
  output logic [IDX_W-1:0]   req_idx,
  output logic               multi
);

  logic w_seen;

  always_comb begin
    req_idx = '0;
    multi   = 1'b0;
    w_seen  = 1'b0;
    for (int unsigned k = 0; k < NUM_MAP; k++) begin
      if (map_active[k]) begin
        if (w_seen) multi = 1'b1;
        w_seen  = 1'b1;
        req_idx = IDX_W'(k + 1);
      end
    end
    if (multi) req_idx = '0;
  end

endmodule

// File: rtl/map_arbiter.sv
// Selects which mapper channel drives the cartridge buses, inserting bus-quiet cycles on owner change.
// Optional conflict logging (conflict_vec, conflict_cnt) is enabled by defining MAP_ARB_CONFLICT_LOG_EN.
module map_arbiter
  import map_arb_pkg::*;
#(
  parameter int unsigned            NUM_MAP       = 5,
  parameter int unsigned            ROM_AW        = 24,
  parameter int unsigned            BSRAM_AW      = 20,
  parameter int unsigned            QUIET_CYC     = 2,
  parameter logic [NUM_MAP-1:0]     NO_TURBO_MASK = 5'b01010,
  parameter int unsigned            CH_ROM_AW     = ROM_AW
) (
  input  logic                              mclk,
  input  logic                              rst_n,
  input  logic [NUM_MAP-1:0]                map_active,
  input  logic [(NUM_MAP+1)*8-1:0]          ch_do,
  input  logic [NUM_MAP:0]                  ch_irq_n,
  input  logic [(NUM_MAP+1)*CH_ROM_AW-1:0]  ch_rom_addr,
  input  logic [NUM_MAP:0]                  ch_rom_ce_n,
  input  logic [NUM_MAP:0]                  ch_rom_oe_n,
  input  logic [NUM_MAP:0]                  ch_rom_word,
  input  logic [(NUM_MAP+1)*BSRAM_AW-1:0]   ch_bsram_addr,
  input  logic [(NUM_MAP+1)*8-1:0]          ch_bsram_d,
  input  logic [NUM_MAP:0]                  ch_bsram_ce_n,
  input  logic [NUM_MAP:0]                  ch_bsram_oe_n,
  input  logic [NUM_MAP:0]                  ch_bsram_we_n,
  output logic [7:0]                        di,
  output logic                              irq_n,
  output logic [ROM_AW-1:0]                 rom_addr,
  output logic                              rom_ce_n,
  output logic                              rom_oe_n,
  output logic                              rom_word,
  output logic [BSRAM_AW-1:0]               bsram_addr,
  output logic [7:0]                        bsram_d,
  output logic                              bsram_ce_n,
  output logic                              bsram_oe_n,
  output logic                              bsram_we_n,
  output logic [$clog2(NUM_MAP+1)-1:0]      sel_idx,
  output logic                              switching,
  output logic                              conflict,
  output logic                              turbo_allow
`ifdef MAP_ARB_CONFLICT_LOG_EN
  ,
  output logic [NUM_MAP-1:0]                conflict_vec,
  output logic [7:0]                        conflict_cnt
`endif
);

  localparam int unsigned      IDX_W   = $clog2(NUM_MAP + 1);
  localparam logic [3:0]       RELOAD  = (QUIET_CYC == 0) ? 4'd0 : 4'(QUIET_CYC - 1);
  localparam logic [NUM_MAP:0] NT_FULL = {NO_TURBO_MASK, 1'b0};

  map_state_t       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_cur_idx, w_cur_nxt;
  logic [IDX_W-1:0] r_pend_idx, w_pend_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic             r_conflict;

  logic [IDX_W-1:0] w_req_idx;
  logic             w_multi;
  logic [IDX_W-1:0] w_mux_idx;

  logic [7:0]           w_do;
  logic                 w_irq_n;
  logic [CH_ROM_AW-1:0] w_rom_addr;
  logic                 w_rom_ce_n, w_rom_oe_n, w_rom_word;
  logic [BSRAM_AW-1:0]  w_bsram_addr;
  logic [7:0]           w_bsram_d;
  logic                 w_bsram_ce_n, w_bsram_oe_n, w_bsram_we_n;

  map_onehot_dec #(
    .NUM_MAP (NUM_MAP),
    .IDX_W   (IDX_W)
  ) u_dec (
    .map_active (map_active),
    .req_idx    (w_req_idx),
    .multi      (w_multi)
  );

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= OWN;
      r_cur_idx  <= IDX_W'(DFLT_CH);
      r_pend_idx <= IDX_W'(DFLT_CH);
      r_cnt      <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur_idx  <= w_cur_nxt;
      r_pend_idx <= w_pend_nxt;
      r_cnt      <= w_cnt_nxt;
      r_conflict <= r_conflict | w_multi;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur_idx;
    w_pend_nxt  = r_pend_idx;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      OWN: begin
        if (w_req_idx != r_cur_idx) begin
          if (QUIET_CYC == 0) begin
            w_cur_nxt = w_req_idx;
          end else begin
            w_pend_nxt  = w_req_idx;
            w_cnt_nxt   = RELOAD;
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        // A changed request restarts the quiet window, even on the final count.
        if (w_req_idx != r_pend_idx) begin
          w_pend_nxt = w_req_idx;
          w_cnt_nxt  = RELOAD;
        end else if (r_cnt == '0) begin
          w_cur_nxt   = r_pend_idx;
          w_state_nxt = OWN;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = OWN;
    endcase
  end

  assign w_mux_idx = (r_state == DRAIN) ? r_pend_idx : r_cur_idx;

  always_comb begin
    w_do         = '0;
    w_irq_n      = 1'b1;
    w_rom_addr   = '0;
    w_rom_ce_n   = 1'b1;
    w_rom_oe_n   = 1'b1;
    w_rom_word   = 1'b0;
    w_bsram_addr = '0;
    w_bsram_d    = '0;
    w_bsram_ce_n = 1'b1;
    w_bsram_oe_n = 1'b1;
    w_bsram_we_n = 1'b1;
    for (int unsigned ch = 0; ch <= NUM_MAP; ch++) begin
      if (IDX_W'(ch) == w_mux_idx) begin
        w_do         = ch_do[ch*8 +: 8];
        w_irq_n      = ch_irq_n[ch];
        w_rom_addr   = ch_rom_addr[ch*CH_ROM_AW +: CH_ROM_AW];
        w_rom_ce_n   = ch_rom_ce_n[ch];
        w_rom_oe_n   = ch_rom_oe_n[ch];
        w_rom_word   = ch_rom_word[ch];
        w_bsram_addr = ch_bsram_addr[ch*BSRAM_AW +: BSRAM_AW];
        w_bsram_d    = ch_bsram_d[ch*8 +: 8];
        w_bsram_ce_n = ch_bsram_ce_n[ch];
        w_bsram_oe_n = ch_bsram_oe_n[ch];
        w_bsram_we_n = ch_bsram_we_n[ch];
      end
    end
  end

  always_comb begin
    di         = w_do;
    irq_n      = w_irq_n;
    rom_addr   = ROM_AW'(w_rom_addr);
    rom_ce_n   = w_rom_ce_n;
    rom_oe_n   = w_rom_oe_n;
    rom_word   = w_rom_word;
    bsram_addr = w_bsram_addr;
    bsram_d    = w_bsram_d;
    bsram_ce_n = w_bsram_ce_n;
    bsram_oe_n = w_bsram_oe_n;
    bsram_we_n = w_bsram_we_n;
    if (r_state == DRAIN) begin
      di         = DRAIN_DI;
      irq_n      = 1'b1;
      rom_ce_n   = 1'b1;
      rom_oe_n   = 1'b1;
      bsram_ce_n = 1'b1;
      bsram_oe_n = 1'b1;
      bsram_we_n = 1'b1;
    end
  end

  assign sel_idx     = r_cur_idx;
  assign switching   = (r_state == DRAIN);
  assign conflict    = r_conflict;
  assign turbo_allow = (r_state == OWN) && !NT_FULL[r_cur_idx];

`ifdef MAP_ARB_CONFLICT_LOG_EN
  logic [NUM_MAP-1:0] r_conflict_vec;
  logic [7:0]         r_conflict_cnt;
  logic               r_multi_d;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_vec <= '0;
      r_conflict_cnt <= '0;
      r_multi_d      <= 1'b0;
    end else begin
      r_multi_d <= w_multi;
      if (w_multi && !r_conflict) r_conflict_vec <= map_active;
      if (w_multi && !r_multi_d && (r_conflict_cnt != 8'hFF))
        r_conflict_cnt <= r_conflict_cnt + 8'd1;
    end
  end

  assign conflict_vec = r_conflict_vec;
  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_map_arbiter.sv
// Scoreboard bench for map_arbiter: QUIET_CYC=2 instance plus a QUIET_CYC=0 instance.
module tb_map_arbiter;

  localparam int NM = 5;
  localparam int NC = NM + 1;

  typedef struct packed {
    logic [2:0]  sel;
    logic        sw;
    logic        turbo;
    logic        conf;
    logic        rom_ce_n;
    logic        irq_n;
    logic [7:0]  di;
    logic [23:0] rom_addr;
    logic        bsram_we_n;
  } obs_t;

  typedef struct {
    string name;
    int    due;
    bit    q0;
    obs_t  exp;
  } exp_t;

  logic mclk;
  logic rst_n;
  logic [NM-1:0] map_m, map_q0;
  logic [NC*8-1:0]  ch_do, ch_bsram_d;
  logic [NC-1:0]    ch_irq_n, ch_rom_ce_n, ch_rom_oe_n, ch_rom_word;
  logic [NC-1:0]    ch_bsram_ce_n, ch_bsram_oe_n, ch_bsram_we_n;
  logic [NC*16-1:0] ch_rom_addr;
  logic [NC*20-1:0] ch_bsram_addr;

  logic [7:0]  di_m, di_q, bsd_m, bsd_q;
  logic        irq_m, irq_q, rce_m, rce_q, roe_m, roe_q, rw_m, rw_q;
  logic [23:0] ra_m, ra_q;
  logic [19:0] ba_m, ba_q;
  logic        bce_m, bce_q, boe_m, boe_q, bwe_m, bwe_q;
  logic [2:0]  sel_m, sel_q;
  logic        sw_m, sw_q, conf_m, conf_q, tb_m, tb_q;
`ifdef MAP_ARB_CONFLICT_LOG_EN
  logic [NM-1:0] cv_m, cv_q;
  logic [7:0]    cc_m, cc_q;
`endif

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  map_arbiter #(
    .NUM_MAP(5), .ROM_AW(24), .BSRAM_AW(20), .QUIET_CYC(2),
    .NO_TURBO_MASK(5'b01010), .CH_ROM_AW(16)
  ) u_dut (
    .mclk(mclk), .rst_n(rst_n), .map_active(map_m),
    .ch_do(ch_do), .ch_irq_n(ch_irq_n), .ch_rom_addr(ch_rom_addr),
    .ch_rom_ce_n(ch_rom_ce_n), .ch_rom_oe_n(ch_rom_oe_n), .ch_rom_word(ch_rom_word),
    .ch_bsram_addr(ch_bsram_addr), .ch_bsram_d(ch_bsram_d), .ch_bsram_ce_n(ch_bsram_ce_n),
    .ch_bsram_oe_n(ch_bsram_oe_n), .ch_bsram_we_n(ch_bsram_we_n),
    .di(di_m), .irq_n(irq_m), .rom_addr(ra_m), .rom_ce_n(rce_m), .rom_oe_n(roe_m),
    .rom_word(rw_m), .bsram_addr(ba_m), .bsram_d(bsd_m), .bsram_ce_n(bce_m),
    .bsram_oe_n(boe_m), .bsram_we_n(bwe_m), .sel_idx(sel_m), .switching(sw_m),
    .conflict(conf_m), .turbo_allow(tb_m)
`ifdef MAP_ARB_CONFLICT_LOG_EN
    , .conflict_vec(cv_m), .conflict_cnt(cc_m)
`endif
  );

  map_arbiter #(
    .NUM_MAP(5), .ROM_AW(24), .BSRAM_AW(20), .QUIET_CYC(0),
    .NO_TURBO_MASK(5'b01010), .CH_ROM_AW(16)
  ) u_dut_q0 (
    .mclk(mclk), .rst_n(rst_n), .map_active(map_q0),
    .ch_do(ch_do), .ch_irq_n(ch_irq_n), .ch_rom_addr(ch_rom_addr),
    .ch_rom_ce_n(ch_rom_ce_n), .ch_rom_oe_n(ch_rom_oe_n), .ch_rom_word(ch_rom_word),
    .ch_bsram_addr(ch_bsram_addr), .ch_bsram_d(ch_bsram_d), .ch_bsram_ce_n(ch_bsram_ce_n),
    .ch_bsram_oe_n(ch_bsram_oe_n), .ch_bsram_we_n(ch_bsram_we_n),
    .di(di_q), .irq_n(irq_q), .rom_addr(ra_q), .rom_ce_n(rce_q), .rom_oe_n(roe_q),
    .rom_word(rw_q), .bsram_addr(ba_q), .bsram_d(bsd_q), .bsram_ce_n(bce_q),
    .bsram_oe_n(boe_q), .bsram_we_n(bwe_q), .sel_idx(sel_q), .switching(sw_q),
    .conflict(conf_q), .turbo_allow(tb_q)
`ifdef MAP_ARB_CONFLICT_LOG_EN
    , .conflict_vec(cv_q), .conflict_cnt(cc_q)
`endif
  );

  obs_t obs_m, obs_q;
  assign obs_m = {sel_m, sw_m, tb_m, conf_m, rce_m, irq_m, di_m, ra_m, bwe_m};
  assign obs_q = {sel_q, sw_q, tb_q, conf_q, rce_q, irq_q, di_q, ra_q, bwe_q};

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  always @(posedge mclk) cyc <= cyc + 1;

  // Channel k: do=0x10+k, irq_n high on even k, rom_addr=0xA000+k, all strobes active.
  function automatic obs_t own(int k, bit turbo, bit conf);
    obs_t o;
    o.sel = 3'(k);  o.sw = 1'b0;  o.turbo = turbo;  o.conf = conf;
    o.rom_ce_n = 1'b0;  o.irq_n = (k % 2 == 0);
    o.di = 8'(8'h10 + k);  o.rom_addr = 24'(24'h00A000 + k);  o.bsram_we_n = 1'b0;
    return o;
  endfunction

  function automatic obs_t drain(int cur, int pend, bit conf);
    obs_t o;
    o.sel = 3'(cur);  o.sw = 1'b1;  o.turbo = 1'b0;  o.conf = conf;
    o.rom_ce_n = 1'b1;  o.irq_n = 1'b1;
    o.di = 8'hFF;  o.rom_addr = 24'(24'h00A000 + pend);  o.bsram_we_n = 1'b1;
    return o;
  endfunction

  task automatic exp_at(string nm, int off, bit q0, obs_t e);
    exp_t x;
    x.name = nm;  x.due = cyc + off;  x.q0 = q0;  x.exp = e;
    sb.push_back(x);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    obs_t act;
    forever begin
      @(negedge mclk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        act = e.q0 ? obs_q : obs_m;
        checks++;
        if (e.due != cyc) begin
          errors++;
          $display("FAIL %s: not sampled at cycle %0d (now %0d)", e.name, e.due, cyc);
        end else if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h want %h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n  = 1'b0;
    map_m  = '0;
    map_q0 = '0;
    for (int k = 0; k < NC; k++) begin
      ch_do[k*8 +: 8]          = 8'(8'h10 + k);
      ch_bsram_d[k*8 +: 8]     = 8'(8'h40 + k);
      ch_irq_n[k]              = (k % 2 == 0);
      ch_rom_addr[k*16 +: 16]  = 16'(16'hA000 + k);
      ch_bsram_addr[k*20 +: 20] = 20'(20'h30000 + k);
    end
    ch_rom_ce_n = '0;  ch_rom_oe_n = '0;  ch_rom_word = '1;
    ch_bsram_ce_n = '0;  ch_bsram_oe_n = '0;  ch_bsram_we_n = '0;

    step(2);
    exp_at("rst_hold", 0, 0, own(0, 1, 0));
    exp_at("rst_hold_q0", 0, 1, own(0, 1, 0));
    rst_n = 1'b1;
    step(1);
    exp_at("post_rst", 0, 0, own(0, 1, 0));

    map_m = 5'b00100;
    exp_at("q2_req", 0, 0, own(0, 1, 0));
    exp_at("q2_drain1", 1, 0, drain(0, 3, 0));
    exp_at("q2_drain2", 2, 0, drain(0, 3, 0));
    exp_at("q2_own3", 3, 0, own(3, 1, 0));
    step(3);

    map_m = '0;
    exp_at("back_drain", 1, 0, drain(3, 0, 0));
    exp_at("back_own0", 3, 0, own(0, 1, 0));
    step(3);

    map_m = 5'b00100;
    exp_at("mid_d1", 1, 0, drain(0, 3, 0));
    step(1);
    map_m = 5'b01000;
    exp_at("mid_reload", 1, 0, drain(0, 4, 0));
    exp_at("mid_d2", 2, 0, drain(0, 4, 0));
    exp_at("mid_own4", 3, 0, own(4, 0, 0));
    step(3);

    map_m = 5'b00011;
    exp_at("conf_pre", 0, 0, own(4, 0, 0));
    exp_at("conf_drain", 1, 0, drain(4, 0, 1));
    exp_at("conf_own0", 3, 0, own(0, 1, 1));
    step(3);
    map_m = '0;
    exp_at("conf_sticky", 2, 0, own(0, 1, 1));
    step(2);

    map_m = 5'b00100;
    exp_at("rev_d1", 1, 0, drain(0, 3, 1));
    step(1);
    map_m = '0;
    exp_at("rev_reload", 1, 0, drain(0, 0, 1));
    exp_at("rev_d2", 2, 0, drain(0, 0, 1));
    exp_at("rev_own0", 3, 0, own(0, 1, 1));
    step(3);

`ifdef MAP_ARB_CONFLICT_LOG_EN
    checks++;
    if (cv_m !== 5'b00011) begin
      errors++;
      $display("FAIL conflict_vec: got %b want 00011", cv_m);
    end
    checks++;
    if (cc_m !== 8'd1) begin
      errors++;
      $display("FAIL conflict_cnt: got %0d want 1", cc_m);
    end
`endif

    map_m = 5'b00100;
    exp_at("rst_pre", 1, 0, drain(0, 3, 1));
    step(2);
    rst_n = 1'b0;
    map_m = '0;
    exp_at("rst_async", 0, 0, own(0, 1, 0));
    exp_at("rst_async_q0", 0, 1, own(0, 1, 0));
    step(1);
    rst_n = 1'b1;
    exp_at("rst_rel", 0, 0, own(0, 1, 0));
    step(2);
    exp_at("rst_clean", 0, 0, own(0, 1, 0));

    map_q0 = 5'b00001;
    exp_at("q0_req", 0, 1, own(0, 1, 0));
    exp_at("q0_own1", 1, 1, own(1, 1, 0));
    exp_at("q0_hold1", 2, 1, own(1, 1, 0));
    step(2);
    map_q0 = 5'b00010;
    exp_at("q0_own2", 1, 1, own(2, 0, 0));
    exp_at("q0_main_idle", 1, 0, own(0, 1, 0));
    step(3);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
